// File: rtl/mu0_mem_arbiter.sv
// Two-master round-robin arbiter sharing the mu0_memory port between the CPU and a loader/debug master.
// Optional master-1 burst lock is built when MU0_ARB_LOCK_EN is defined.
module mu0_mem_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              M0_Rd,
  input  logic              M0_Wr,
  input  logic [ADDR_W-1:0] M0_Address,
  input  logic [DATA_W-1:0] M0_Data_out,
  output logic [DATA_W-1:0] M0_Data_in,
  output logic              M0_Stall,
  input  logic              M1_Req,
  input  logic              M1_We,
  input  logic              M1_Lock,
  input  logic [ADDR_W-1:0] M1_Address,
  input  logic [DATA_W-1:0] M1_Wdata,
  output logic              M1_Gnt,
  output logic [DATA_W-1:0] M1_Rdata,
  output logic              M1_Rvalid,
  output logic              Mem_Rd,
  output logic              Mem_Wr,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_Data_out,
  input  logic [DATA_W-1:0] Mem_Data_in
);

  localparam int unsigned LOCK_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_M0   = 2'd1,
    RD_M1   = 2'd2
  } rd_owner_t;

  logic      req0;
  logic      req1;
  logic      grant0;
  logic      grant1;
  logic      pick1;
  logic      last_q;
  logic      last_d;
  rd_owner_t rd_owner_q;
  rd_owner_t rd_owner_d;
  logic      lock_hold;
  logic      lock_yield;

  assign req0 = M0_Rd | M0_Wr;
  assign req1 = M1_Req;

`ifdef MU0_ARB_LOCK_EN
  logic [LOCK_W-1:0] lock_cnt_q;
  logic [LOCK_W-1:0] lock_cnt_d;

  // A running lock keeps master 1 in front until MAX_LOCK grants, then master 0 gets one turn.
  assign lock_hold  = M1_Lock && (lock_cnt_q != '0) && (lock_cnt_q < LOCK_W'(MAX_LOCK));
  assign lock_yield = (lock_cnt_q == LOCK_W'(MAX_LOCK));

  always_comb begin
    lock_cnt_d = '0;
    if (grant1 && M1_Lock) begin
      lock_cnt_d = lock_yield ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  logic [LOCK_W-1:0] lock_unused;

  assign lock_unused = LOCK_W'(M1_Lock);
  assign lock_hold   = 1'b0;
  assign lock_yield  = 1'b0;
`endif

  // Grant decision and memory port steering, all within the request cycle.
  always_comb begin
    grant0       = 1'b0;
    grant1       = 1'b0;
    pick1        = 1'b0;
    Mem_Rd       = 1'b0;
    Mem_Wr       = 1'b0;
    Mem_Address  = '0;
    Mem_Data_out = '0;
    if (!Reset) begin
      if (req0 && req1) begin
        if (lock_hold) begin
          pick1 = 1'b1;
        end else if (lock_yield) begin
          pick1 = 1'b0;
        end else begin
          pick1 = ~last_q;
        end
        grant1 = pick1;
        grant0 = ~pick1;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
    if (grant0) begin
      Mem_Wr       = M0_Wr;
      Mem_Rd       = M0_Rd & ~M0_Wr;
      Mem_Address  = M0_Address;
      Mem_Data_out = M0_Data_out;
    end else if (grant1) begin
      Mem_Wr       = M1_We;
      Mem_Rd       = ~M1_We;
      Mem_Address  = M1_Address;
      Mem_Data_out = M1_Wdata;
    end
    M0_Stall = req0 & ~grant0 & ~Reset;
    M1_Gnt   = grant1;
  end

  always_comb begin
    last_d     = last_q;
    rd_owner_d = RD_NONE;
    if (grant0 || grant1) begin
      last_d = grant1;
    end
    if (Mem_Rd) begin
      rd_owner_d = grant1 ? RD_M1 : RD_M0;
    end
  end

  // last resets to master 1 so that master 0 wins the first conflict.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_q     <= 1'b1;
      rd_owner_q <= RD_NONE;
    end else begin
      last_q     <= last_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign M0_Data_in = Mem_Data_in;
  assign M1_Rdata   = Mem_Data_in;
  // Reset in the data cycle drops the in-flight master-1 read.
  assign M1_Rvalid  = (rd_owner_q == RD_M1) & ~Reset;

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Randomized scoreboard bench for mu0_mem_arbiter with a behavioural memory and arbitration model.
module tb_mu0_mem_arbiter;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned MAX_LOCK = 4;

  logic              Clk;
  logic              Reset;
  logic              M0_Rd;
  logic              M0_Wr;
  logic [ADDR_W-1:0] M0_Address;
  logic [DATA_W-1:0] M0_Data_out;
  logic [DATA_W-1:0] M0_Data_in;
  logic              M0_Stall;
  logic              M1_Req;
  logic              M1_We;
  logic              M1_Lock;
  logic [ADDR_W-1:0] M1_Address;
  logic [DATA_W-1:0] M1_Wdata;
  logic              M1_Gnt;
  logic [DATA_W-1:0] M1_Rdata;
  logic              M1_Rvalid;
  logic              Mem_Rd;
  logic              Mem_Wr;
  logic [ADDR_W-1:0] Mem_Address;
  logic [DATA_W-1:0] Mem_Data_out;
  logic [DATA_W-1:0] Mem_Data_in;

  mu0_mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_LOCK(MAX_LOCK)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .M0_Rd       (M0_Rd),
    .M0_Wr       (M0_Wr),
    .M0_Address  (M0_Address),
    .M0_Data_out (M0_Data_out),
    .M0_Data_in  (M0_Data_in),
    .M0_Stall    (M0_Stall),
    .M1_Req      (M1_Req),
    .M1_We       (M1_We),
    .M1_Lock     (M1_Lock),
    .M1_Address  (M1_Address),
    .M1_Wdata    (M1_Wdata),
    .M1_Gnt      (M1_Gnt),
    .M1_Rdata    (M1_Rdata),
    .M1_Rvalid   (M1_Rvalid),
    .Mem_Rd      (Mem_Rd),
    .Mem_Wr      (Mem_Wr),
    .Mem_Address (Mem_Address),
    .Mem_Data_out(Mem_Data_out),
    .Mem_Data_in (Mem_Data_in)
  );

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [15:0] mem     [4096];
  logic [15:0] ref_mem [4096];
  exp_t        q0[$];
  exp_t        q1[$];
  int          m_last   = 1;
  int          m_lock   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int a);
    return 16'((a * 257) ^ 16'h5A5A);
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = init_val(i);
      ref_mem[i] = init_val(i);
    end
    mem[12'h00A]     = 16'h1234;
    ref_mem[12'h00A] = 16'h1234;
  end

  // Synchronous memory: data appears the cycle after Mem_Rd.
  always @(posedge Clk) begin
    if (Mem_Wr) mem[Mem_Address] <= Mem_Data_out;
    if (Mem_Rd) Mem_Data_in <= mem[Mem_Address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: decides who should own the port and what data each master should see.
  always @(negedge Clk) begin : model
    logic        r0, r1, g0, g1, rd, wr;
    logic [11:0] a;
    logic [15:0] d;
    g0 = 1'b0; g1 = 1'b0; rd = 1'b0; wr = 1'b0; a = '0; d = '0;
    if (Reset) begin
      m_last = 1;
      m_lock = 0;
      q0.delete();
      q1.delete();
    end else begin
      r0 = M0_Rd | M0_Wr;
      r1 = M1_Req;
      if (r0 && r1) begin
`ifdef MU0_ARB_LOCK_EN
        if (M1_Lock && m_lock >= 1 && m_lock < int'(MAX_LOCK)) g1 = 1'b1;
        else if (m_lock == int'(MAX_LOCK)) g1 = 1'b0;
        else g1 = (m_last == 0);
`else
        g1 = (m_last == 0);
`endif
        g0 = ~g1;
      end else begin
        g0 = r0;
        g1 = r1;
      end
      if (g0) begin
        wr = M0_Wr; rd = M0_Rd & ~M0_Wr; a = M0_Address; d = M0_Data_out;
      end else if (g1) begin
        wr = M1_We; rd = ~M1_We; a = M1_Address; d = M1_Wdata;
      end
    end
    chk("m1_gnt", 32'(M1_Gnt), 32'(g1));
    chk("m0_stall", 32'(M0_Stall), 32'(!Reset && (M0_Rd | M0_Wr) && !g0));
    chk("mem_rd", 32'(Mem_Rd), 32'(rd));
    chk("mem_wr", 32'(Mem_Wr), 32'(wr));
    chk("mem_addr", 32'(Mem_Address), 32'(a));
    chk("mem_wdata", 32'(Mem_Data_out), 32'(d));
    if (!Reset) begin
      if (g0 || g1) m_last = g1 ? 1 : 0;
      if (g1 && M1_Lock) m_lock = (m_lock < int'(MAX_LOCK)) ? m_lock + 1 : m_lock;
      else m_lock = 0;
      if (wr) ref_mem[a] = d;
      if (rd && g0) q0.push_back('{cyc + 1, ref_mem[a]});
      if (rd && g1) q1.push_back('{cyc + 1, ref_mem[a]});
    end
  end

  // Monitor: pops expected read data when the DUT presents it.
  always @(negedge Clk) begin : monitor
    exp_t e;
    #1;
    if (M1_Rvalid) begin
      if (q1.size() == 0 || q1[0].cyc != cyc) begin
        chk("m1_rvalid", 32'(M1_Rvalid), 32'd0);
      end else begin
        e = q1.pop_front();
        chk("m1_rdata", 32'(M1_Rdata), 32'(e.data));
      end
    end else if (q1.size() > 0 && q1[0].cyc == cyc) begin
      e = q1.pop_front();
      chk("m1_rvalid", 32'(M1_Rvalid), 32'd1);
    end
    if (q0.size() > 0 && q0[0].cyc == cyc) begin
      e = q0.pop_front();
      chk("m0_data_in", 32'(M0_Data_in), 32'(e.data));
    end
  end

  task automatic drive(input logic rst, input logic m0rd, input logic m0wr,
                       input logic [11:0] a0, input logic [15:0] d0,
                       input logic m1req, input logic m1we, input logic m1lock,
                       input logic [11:0] a1, input logic [15:0] d1);
    @(posedge Clk);
    #1;
    Reset = rst; M0_Rd = m0rd; M0_Wr = m0wr; M0_Address = a0; M0_Data_out = d0;
    M1_Req = m1req; M1_We = m1we; M1_Lock = m1lock; M1_Address = a1; M1_Wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
  endtask

  function automatic logic lock_pattern(input int i);
`ifdef MU0_ARB_LOCK_EN
    return (i < int'(MAX_LOCK)) ? 1'b1 : 1'b0;
`else
    return (i % 2 == 0) ? 1'b1 : 1'b0;
`endif
  endfunction

  initial begin
    Reset = 1'b1; M0_Rd = 1'b0; M0_Wr = 1'b0; M0_Address = '0; M0_Data_out = '0;
    M1_Req = 1'b0; M1_We = 1'b0; M1_Lock = 1'b0; M1_Address = '0; M1_Wdata = '0;
    do_reset();
    do_reset();
    // Reset with requests pending: nothing is granted.
    drive(1'b1, 1'b1, 1'b0, 12'h00A, 16'h0, 1'b1, 1'b0, 1'b0, 12'h002, 16'h0);
    @(negedge Clk);
    chk("rst_stall", 32'(M0_Stall), 32'd0);
    chk("rst_gnt", 32'(M1_Gnt), 32'd0);

    // CPU read of 0x00A.
    drive(1'b0, 1'b1, 1'b0, 12'h00A, 16'h0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
    @(negedge Clk);
    chk("t1_mem_rd", 32'(Mem_Rd), 32'd1);
    chk("t1_stall", 32'(M0_Stall), 32'd0);
    idle();
    @(negedge Clk);
    chk("t1_data", 32'(M0_Data_in), 32'h1234);
    chk("t1_m1_rvalid", 32'(M1_Rvalid), 32'd0);

    // First conflict after reset goes to the CPU.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 12'h001, 16'h0, 1'b1, 1'b0, 1'b0, 12'h002, 16'h0);
    @(negedge Clk);
    chk("t2_gnt0", 32'(M1_Gnt), 32'd0);
    chk("t2_stall0", 32'(M0_Stall), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 12'h001, 16'h0, 1'b1, 1'b0, 1'b0, 12'h002, 16'h0);
    @(negedge Clk);
    chk("t2_gnt1", 32'(M1_Gnt), 32'd1);
    chk("t2_stall1", 32'(M0_Stall), 32'd1);
    idle();
    @(negedge Clk);
    chk("t2_rvalid", 32'(M1_Rvalid), 32'd1);
    chk("t2_rdata", 32'(M1_Rdata), 32'(init_val(2)));

    // Continuous conflict alternates, starting with the CPU.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 12'h003, 16'h0, 1'b1, 1'b0, 1'b0, 12'h004, 16'h0);
      @(negedge Clk);
      chk("t3_gnt", 32'(M1_Gnt), 32'(i % 2));
      chk("t3_stall", 32'(M0_Stall), 32'(i % 2));
    end

    // Rd and Wr together is a write.
    drive(1'b0, 1'b1, 1'b1, 12'h010, 16'hBEEF, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
    @(negedge Clk);
    chk("t4_wr", 32'(Mem_Wr), 32'd1);
    chk("t4_rd", 32'(Mem_Rd), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 12'h010, 16'h0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
    idle();
    @(negedge Clk);
    chk("t4_readback", 32'(M0_Data_in), 32'hBEEF);

    // Locked burst under continuous conflict, starting from a master-1 win.
    for (int i = 0; i < int'(MAX_LOCK) + 1; i++) begin
      drive(1'b0, 1'b1, 1'b0, 12'h006, 16'h0, 1'b1, 1'b0, 1'b1, 12'h007, 16'h0);
      @(negedge Clk);
      chk("t5_lock_gnt", 32'(M1_Gnt), 32'(lock_pattern(i)));
    end
    idle();

    // Reset during the data cycle of a master-1 read drops it.
    drive(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b1, 1'b0, 1'b0, 12'h008, 16'h0);
    do_reset();
    @(negedge Clk);
    chk("t6_rvalid", 32'(M1_Rvalid), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 12'h009, 16'h0, 1'b1, 1'b0, 1'b0, 12'h00B, 16'h0);
    @(negedge Clk);
    chk("t6_gnt", 32'(M1_Gnt), 32'd0);
    chk("t6_stall", 32'(M0_Stall), 32'd0);

    // Random traffic over a small address window for read-after-write hits.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
            12'($urandom_range(0, 31)), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            12'($urandom_range(0, 31)), 16'($urandom));
    end
    idle();
    idle();
    idle();
    @(negedge Clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mu0_mem_arbiter.md
# mu0_mem_arbiter

Two-master memory arbiter placed between the MU0 core and `mu0_memory`. It shares the single memory port between the CPU (master 0) and a loader/debug master (master 1, e.g. a program loader or memory inspector). Round-robin arbitration applies on contention, and the CPU is stalled while master 1 owns the port. Each transaction is one memory-port cycle, and read data is steered back to its issuing master one cycle later.

## Interface
- `ADDR_W`, 12, address width (matches MU0 `Address`)
- `DATA_W`, 16, data width
- `MAX_LOCK`, 8, maximum consecutive master-1 grants while locked (only used with `MU0_ARB_LOCK_EN`)

- `Clk` in 1: single clock, rising edge
- `Reset` in 1: synchronous, active-high
- `M0_Rd` in 1: CPU read request
- `M0_Wr` in 1: CPU write request
- `M0_Address` in `ADDR_W`: CPU address
- `M0_Data_out` in `DATA_W`: CPU write data
- `M0_Data_in` out `DATA_W`: CPU read data
- `M0_Stall` out 1: CPU request not granted this cycle; CPU holds all request signals
- `M1_Req` in 1: master-1 request
- `M1_We` in 1: master-1 write (1) / read (0)
- `M1_Lock` in 1: master-1 burst-lock request
- `M1_Address` in `ADDR_W`: master-1 address
- `M1_Wdata` in `DATA_W`: master-1 write data
- `M1_Gnt` out 1: master-1 request accepted this cycle
- `M1_Rdata` out `DATA_W`: master-1 read data
- `M1_Rvalid` out 1: `M1_Rdata` valid this cycle
- `Mem_Rd` out 1: memory read strobe
- `Mem_Wr` out 1: memory write strobe
- `Mem_Address` out `ADDR_W`: memory address
- `Mem_Data_out` out `DATA_W`: memory write data
- `Mem_Data_in` in `DATA_W`: memory read data, valid the cycle after `Mem_Rd`

## Operation
- Requests: `req0 = M0_Rd | M0_Wr`, `req1 = M1_Req`. `M0_Wr` and `M0_Rd` both high is a write; `Mem_Rd` is suppressed.
- Registered state: `last` (last granted master), `rd_owner` (0/1/none), `lock_cnt` (`$clog2(MAX_LOCK+1)` bits).
- Grant decision is combinational within the cycle:
  - only `req0`: grant 0
  - only `req1`: grant 1
  - both: grant the master that is not `last`
  - neither: idle, with `Mem_Rd`/`Mem_Wr` low and `Mem_Address`/`Mem_Data_out` = 0
- The granted master's address, data and strobe drive the `Mem_*` outputs in the same cycle.
- `M0_Stall = req0 & ~grant0`.
- `M1_Gnt = grant1`.
- On each grant edge, `last` updates to the granted master.
- On a granted read, `rd_owner` is set to that master; otherwise it is set to none.
- `M0_Data_in` and `M1_Rdata` both pass `Mem_Data_in` through unchanged.
- `M1_Rvalid` is registered: it is high in cycle N+1 when `rd_owner` = 1.

## Timing
- Grant, stall and memory strobes have zero-cycle latency from the requests.
- Read data arrives 1 cycle after the grant, for both masters.
- A stalled master 0 retries every cycle and wins at the latest on the next cycle. The exception is an active lock (see Configuration), which extends the wait to at most `MAX_LOCK` cycles.
- Back-to-back grants to the same master are allowed when the other master is idle.
- When `Reset` is high:
  - combinationally: no grants, `Mem_Rd`/`Mem_Wr`/`M1_Gnt`/`M0_Stall` = 0, `Mem_Address`/`Mem_Data_out` = 0
  - at the edge: `last` = 1 (so master 0 wins the first conflict), `rd_owner` = none, `lock_cnt` = 0, `M1_Rvalid` = 0
- Reset asserted in the cycle after a read grant: `M1_Rvalid` is forced to 0, and the in-flight read is dropped.

## Configuration
- `MU0_ARB_LOCK_EN` defined:
  - A master-1 grant with `M1_Lock` = 1 increments `lock_cnt`.
  - While `lock_cnt` is between 1 and `MAX_LOCK`-1 inclusive, `req1 & M1_Lock` wins any conflict regardless of `last`.
  - When `lock_cnt` reaches `MAX_LOCK`, master 0 wins the next conflict, and `lock_cnt` clears on that grant.
  - `lock_cnt` clears on any cycle without a locked master-1 grant.
- `MU0_ARB_LOCK_EN` undefined: `M1_Lock` is ignored, `lock_cnt` is absent, and arbitration is pure round-robin.

## Test plan
- Reset, then `M0_Rd` with `M0_Address` = 0x00A and memory[0x00A] = 0x1234: `Mem_Rd` = 1 and `M0_Stall` = 0 in cycle N; `M0_Data_in` = 0x1234 in N+1; `M1_Rvalid` stays 0.
- First conflict after reset, with `M0_Rd` @0x001 and `M1_Req` read @0x002 in the same cycle: master 0 is granted and `M1_Gnt` = 0. In the next cycle `M1_Gnt` = 1 and `M0_Stall` = 1 (if `M0_Rd` is held). In the cycle after that, `M1_Rvalid` = 1 with `M1_Rdata` = memory[0x002].
- Continuous conflict for 6 cycles: grants alternate 0,1,0,1,0,1 and `M0_Stall` pattern is 0,1,0,1,0,1.
- `M0_Wr` = `M0_Rd` = 1, address 0x010, data 0xBEEF: `Mem_Wr` = 1, `Mem_Rd` = 0; a later read of 0x010 returns 0xBEEF.
- With `MU0_ARB_LOCK_EN` and `MAX_LOCK` = 4, `M1_Lock` held high under continuous conflict starting with a master-1 grant: 4 consecutive `M1_Gnt`, then master 0 is granted.
- `Reset` pulsed in the cycle after an M1 read grant: `M1_Rvalid` = 0; after release, the first conflict goes to master 0.
